// File: rtl/game_flow_controller.sv
// Screen sequencer for a flap-style game: title -> play -> game over, with PS2 key consumption and seeding.
// Optional pause on key channel 2 is enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_controller #(
  parameter int NUM_SCREENS    = 3,
  parameter int NUM_KEYS       = 2,
  parameter int SEED_WIDTH     = 32,
  parameter int HOLDOFF_CYCLES = 50000000
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [2*NUM_KEYS-1:0]          key_state,
  output logic [NUM_KEYS-1:0]            key_ack,
  input  logic                           collision,
  output logic [$clog2(NUM_SCREENS)-1:0] screen,
  output logic                           scroll_en,
  output logic                           flap,
  output logic                           rand_reset,
  output logic                           score_clr,
  output logic                           paused,
  output logic [SEED_WIDTH-1:0]          seed_out
);

  localparam int SW = $clog2(NUM_SCREENS);
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SCR_TITLE = '0;
  localparam logic [SW-1:0] SCR_PLAY  = SW'(1);
  localparam logic [SW-1:0] SCR_OVER  = SW'(NUM_SCREENS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    KEY_NONE        = 2'd0,
    KEY_PRESS       = 2'd1,
    KEY_RELEASE     = 2'd2,
    KEY_RELEASE_ALT = 2'd3
  } key_code_e;

  logic [SW-1:0]         screen_q, screen_d;
  logic [NUM_KEYS-1:0]   ack_q, ack_d;
  logic [HW-1:0]         holdoff_q, holdoff_d;
  logic [SEED_WIDTH-1:0] cnt_q, cnt_d;
  logic [SEED_WIDTH-1:0] seed_q, seed_d;
  logic                  start_q, start_d;
  logic                  flap_q, flap_d;
  logic                  scroll_q, scroll_d;
  logic                  adv_press, flap_press;
  logic                  paused_cur, paused_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ack_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      ack_d[k] = (key_state[2*k +: 2] != KEY_NONE) && !ack_q[k];
    end
    adv_press  = ack_d[0] && (key_state[1:0] == KEY_PRESS);
    flap_press = ack_d[1] && (key_state[3:2] == KEY_PRESS);

    // Collision in play takes priority; a same-edge advance is acked and dropped.
    screen_d = screen_q;
    if (screen_q == SCR_PLAY && collision) begin
      screen_d = SCR_OVER;
    end else if (adv_press && holdoff_q == '0) begin
      screen_d = (screen_q == SCR_OVER) ? SCR_TITLE : screen_q + SW'(1);
    end

    holdoff_d = '0;
    if (screen_d == SCR_OVER && screen_q != SCR_OVER) begin
      holdoff_d = HOLD_LOAD;
    end else if (screen_d == SCR_OVER && holdoff_q != '0) begin
      holdoff_d = holdoff_q - HW'(1);
    end

    start_d = (screen_q == SCR_TITLE) && (screen_d == SCR_PLAY);
    cnt_d   = cnt_q + SEED_WIDTH'(1);
    seed_d  = start_d ? cnt_q : seed_q;
    flap_d  = flap_press && (screen_q == SCR_PLAY) && !paused_cur;
  end

  assign scroll_d = (screen_d == SCR_PLAY) && !paused_next;

`ifdef GAME_FLOW_PAUSE_EN
  logic paused_q;
  logic pause_press;

  if (NUM_KEYS >= 3) begin : g_pause_key
    assign pause_press = ack_d[2] && (key_state[5:4] == KEY_PRESS);
  end else begin : g_no_pause_key
    assign pause_press = 1'b0;
  end

  always_comb begin
    paused_next = paused_q ^ (pause_press && screen_q == SCR_PLAY);
    if (screen_d != SCR_PLAY) paused_next = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) paused_q <= 1'b0;
    else         paused_q <= paused_next;
  end

  assign paused_cur = paused_q;
`else
  assign paused_next = 1'b0;
  assign paused_cur  = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments and clear asynchronously on resetn low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      screen_q  <= SCR_TITLE;
      ack_q     <= '0;
      holdoff_q <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      start_q   <= 1'b0;
      flap_q    <= 1'b0;
      scroll_q  <= 1'b0;
    end else begin
      screen_q  <= screen_d;
      ack_q     <= ack_d;
      holdoff_q <= holdoff_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      start_q   <= start_d;
      flap_q    <= flap_d;
      scroll_q  <= scroll_d;
    end
  end

  assign screen     = screen_q;
  assign key_ack    = ack_q;
  assign scroll_en  = scroll_q;
  assign flap       = flap_q;
  assign rand_reset = start_q;
  assign score_clr  = start_q;
  assign paused     = paused_cur;
  assign seed_out   = seed_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller (3 screens, 3 key channels, hold-off of 10 cycles).
// Observed vector obs = {screen[1:0], key_ack[2:0], scroll_en, flap, rand_reset, score_clr, paused}.
module tb_game_flow_controller;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [5:0]  key_state = '0;
  logic [2:0]  key_ack;
  logic        collision = 1'b0;
  logic [1:0]  screen;
  logic        scroll_en, flap, rand_reset, score_clr, paused;
  logic [31:0] seed_out;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_v;

`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  localparam logic [5:0] K_ADV   = 6'b00_00_01;
  localparam logic [5:0] K_FLAP  = 6'b00_01_00;
  localparam logic [5:0] K_PAUSE = 6'b01_00_00;

  game_flow_controller #(
    .NUM_SCREENS(3), .NUM_KEYS(3), .SEED_WIDTH(32), .HOLDOFF_CYCLES(10)
  ) dut (
    .clock(clock), .resetn(resetn), .key_state(key_state), .key_ack(key_ack),
    .collision(collision), .screen(screen), .scroll_en(scroll_en), .flap(flap),
    .rand_reset(rand_reset), .score_clr(score_clr), .paused(paused), .seed_out(seed_out)
  );

  always #5 clock = ~clock;

  wire [9:0] obs = {screen, key_ack, scroll_en, flap, rand_reset, score_clr, paused};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [9:0] e);
    exp_v = e;
  endtask

  // Reset asserted for two edges, released 1 time unit after an edge.
  task automatic do_reset();
    key_state = '0;
    collision = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic go_play();
    key_state = K_ADV; tick();
    key_state = '0;    tick();
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    checks++; if (obs !== 10'b0) begin errors++; $display("FAIL reset_async: obs=%b exp=%b", obs, 10'b0); end
    checks++; if (seed_out !== 32'd0) begin errors++; $display("FAIL reset_seed: seed=%0d exp=0", seed_out); end
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (obs !== 10'b0) begin errors++; $display("FAIL reset_idle: obs=%b exp=%b", obs, 10'b0); end
  endtask

  task automatic test_start();
    do_reset();
    repeat (4) tick();
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b01_001_1_0_1_1_0) begin errors++; $display("FAIL start_edge: obs=%b exp=%b", obs, 10'b01_001_1_0_1_1_0); end
    checks++; if (seed_out !== 32'd4) begin errors++; $display("FAIL start_seed: seed=%0d exp=4", seed_out); end
    tick();
    checks++; if (obs !== 10'b01_000_1_0_0_0_0) begin errors++; $display("FAIL start_ack_drop: obs=%b exp=%b", obs, 10'b01_000_1_0_0_0_0); end
    tick();
    checks++; if (obs !== 10'b10_001_0_0_0_0_0) begin errors++; $display("FAIL start_second_ack: obs=%b exp=%b", obs, 10'b10_001_0_0_0_0_0); end
    key_state = '0; tick();
    checks++; if (obs !== 10'b10_000_0_0_0_0_0) begin errors++; $display("FAIL start_settle: obs=%b exp=%b", obs, 10'b10_000_0_0_0_0_0); end
    checks++; if (seed_out !== 32'd4) begin errors++; $display("FAIL start_seed_hold: seed=%0d exp=4", seed_out); end
  endtask

  task automatic test_release_and_multi();
    do_reset();
    tick();
    collision = 1'b1; tick();
    collision = 1'b0;
    checks++; if (obs !== 10'b0) begin errors++; $display("FAIL collision_title: obs=%b exp=%b", obs, 10'b0); end
    key_state = 6'b00_00_10; tick();
    checks++; if (obs !== 10'b00_001_0_0_0_0_0) begin errors++; $display("FAIL release_code2: obs=%b exp=%b", obs, 10'b00_001_0_0_0_0_0); end
    key_state = 6'b00_00_11; tick();
    checks++; if (obs !== 10'b0) begin errors++; $display("FAIL release_blocked: obs=%b exp=%b", obs, 10'b0); end
    tick();
    checks++; if (obs !== 10'b00_001_0_0_0_0_0) begin errors++; $display("FAIL release_code3: obs=%b exp=%b", obs, 10'b00_001_0_0_0_0_0); end
    key_state = '0; tick();
    key_state = K_ADV | K_FLAP; tick();
    checks++; if (obs !== 10'b01_011_1_0_1_1_0) begin errors++; $display("FAIL multi_channel: obs=%b exp=%b", obs, 10'b01_011_1_0_1_1_0); end
    key_state = '0; tick();
  endtask

  task automatic test_collision();
    do_reset();
    go_play();
    collision = 1'b1; key_state = K_ADV; tick();
    checks++; if (obs !== 10'b10_001_0_0_0_0_0) begin errors++; $display("FAIL collision_wins: obs=%b exp=%b", obs, 10'b10_001_0_0_0_0_0); end
    collision = 1'b0; key_state = '0; tick();
    checks++; if (obs !== 10'b10_000_0_0_0_0_0) begin errors++; $display("FAIL collision_hold: obs=%b exp=%b", obs, 10'b10_000_0_0_0_0_0); end
  endtask

  task automatic test_holdoff();
    do_reset();
    go_play();
    collision = 1'b1; tick();
    collision = 1'b0;
    repeat (4) tick();
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b10_001_0_0_0_0_0) begin errors++; $display("FAIL holdoff_c5: obs=%b exp=%b", obs, 10'b10_001_0_0_0_0_0); end
    key_state = '0; repeat (4) tick();
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b10_001_0_0_0_0_0) begin errors++; $display("FAIL holdoff_c10: obs=%b exp=%b", obs, 10'b10_001_0_0_0_0_0); end
    key_state = '0; tick();
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b00_001_0_0_0_0_0) begin errors++; $display("FAIL holdoff_c12: obs=%b exp=%b", obs, 10'b00_001_0_0_0_0_0); end
    key_state = '0; tick();
  endtask

  task automatic test_flap();
    do_reset();
    tick();
    key_state = K_FLAP; tick();
    checks++; if (obs !== 10'b00_010_0_0_0_0_0) begin errors++; $display("FAIL flap_title: obs=%b exp=%b", obs, 10'b00_010_0_0_0_0_0); end
    key_state = '0; tick();
    go_play();
    key_state = K_FLAP; tick();
    checks++; if (obs !== 10'b01_010_1_1_0_0_0) begin errors++; $display("FAIL flap_play: obs=%b exp=%b", obs, 10'b01_010_1_1_0_0_0); end
    key_state = '0; tick();
    checks++; if (obs !== 10'b01_000_1_0_0_0_0) begin errors++; $display("FAIL flap_one_cycle: obs=%b exp=%b", obs, 10'b01_000_1_0_0_0_0); end
  endtask

  task automatic test_pause();
    do_reset();
    go_play();
    key_state = K_PAUSE; tick();
    chk("pause_on", {2'd1, 3'b100, !PAUSE, 1'b0, 2'b00, PAUSE});
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pause_on: obs=%b exp=%b", obs, exp_v); end
    key_state = '0; tick();
    key_state = K_FLAP; tick();
    chk("pause_flap", {2'd1, 3'b010, !PAUSE, !PAUSE, 2'b00, PAUSE});
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pause_flap: obs=%b exp=%b", obs, exp_v); end
    key_state = '0; tick();
    key_state = K_PAUSE; tick();
    checks++; if (obs !== 10'b01_100_1_0_0_0_0) begin errors++; $display("FAIL pause_off: obs=%b exp=%b", obs, 10'b01_100_1_0_0_0_0); end
    key_state = '0; tick();
    key_state = K_PAUSE; tick();
    key_state = '0; collision = 1'b1; tick();
    collision = 1'b0;
    checks++; if (obs !== 10'b10_000_0_0_0_0_0) begin errors++; $display("FAIL pause_cleared_over: obs=%b exp=%b", obs, 10'b10_000_0_0_0_0_0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    go_play();
    collision = 1'b1; tick();
    collision = 1'b0;
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b10_001_0_0_0_0_0) begin errors++; $display("FAIL mid_pre_reset: obs=%b exp=%b", obs, 10'b10_001_0_0_0_0_0); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (obs !== 10'b0) begin errors++; $display("FAIL mid_reset_async: obs=%b exp=%b", obs, 10'b0); end
    checks++; if (seed_out !== 32'd0) begin errors++; $display("FAIL mid_reset_seed: seed=%0d exp=0", seed_out); end
    tick();
    key_state = '0;
    resetn = 1'b1;
    repeat (3) tick();
    key_state = K_ADV; tick();
    checks++; if (obs !== 10'b01_001_1_0_1_1_0) begin errors++; $display("FAIL mid_restart: obs=%b exp=%b", obs, 10'b01_001_1_0_1_1_0); end
    checks++; if (seed_out !== 32'd3) begin errors++; $display("FAIL mid_restart_seed: seed=%0d exp=3", seed_out); end
    key_state = '0; tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_release_and_multi();
    test_collision();
    test_holdoff();
    test_flap();
    test_pause();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
